// File: rtl/monotonized_popcount_accumulator_if.sv
// Handshake bundle for the monotonized popcount accumulator: vector input stream
// and per-frame result output. The design sits on the slave side.
interface monotonized_popcount_accumulator_if #(
    parameter int ACC_WIDTH   = 48,
    parameter int COUNT_WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [127:0]           in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_sum;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_overflow;
    logic                   busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow, busy
    );
endinterface

// File: rtl/monotonized_popcount_accumulator.sv
// Per-frame accumulator of popcounts of the upward closure of 128-entry truth tables.
// Pipeline: closure -> 16-bit chunk popcounts -> total -> accumulators.
module monotonized_popcount_accumulator #(
    parameter int ACC_WIDTH   = 48,
    parameter int COUNT_WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    monotonized_popcount_accumulator_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Subset-sum (zeta) transform: after pass b every entry has ORed in the entry without bit b.
    function automatic logic [127:0] upClose(input logic [127:0] d);
        logic [127:0] c;
        logic [6:0]   idx;
        logic [6:0]   bitm;
        logic [6:0]   lo;
        c = d;
        for (int b = 0; b < 7; b++) begin
            for (int i = 0; i < 128; i++) begin
                idx  = 7'(i);
                bitm = 7'd1 << b;
                lo   = idx & ~bitm;
                if ((idx & bitm) != 7'd0) c[idx] = c[idx] | c[lo];
                else                      c[idx] = c[idx];
            end
        end
        return c;
    endfunction

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int k = 0; k < 16; k++) n = n + {4'd0, v[4'(k)]};
        return n;
    endfunction

    logic [1:0]             stateR, stateS;
    logic                   acceptS, outFireS;
    logic                   readyR, validR, busyR;
    logic [127:0]           closureR;
    logic [4:0]             chunkS [8];
    logic [4:0]             chunkR [8];
    logic [7:0]             totalS, totalR;
    logic                   v1R, v2R, v3R;
    logic                   last1R, last2R, last3R;
    logic [ACC_WIDTH-1:0]   sumR;
    logic [COUNT_WIDTH-1:0] countR;
    logic                   ovfR;
    logic [ACC_WIDTH:0]     sumAddS;
    logic [COUNT_WIDTH:0]   cntAddS;

    assign acceptS  = bus.in_valid & readyR;
    assign outFireS = validR & bus.out_ready;

    assign bus.in_ready     = readyR;
    assign bus.out_valid    = validR;
    assign bus.busy         = busyR;
    assign bus.out_sum      = sumR;
    assign bus.out_count    = countR;
    assign bus.out_overflow = ovfR;

    // Frame-level next-state decode.
    always_comb begin
        stateS = stateR;
        case (stateR)
            IDLE: begin
                if (acceptS) stateS = bus.in_last ? DRAIN : ACCUM;
                else         stateS = IDLE;
            end
            ACCUM: begin
                if (acceptS && bus.in_last) stateS = DRAIN;
                else                        stateS = ACCUM;
            end
            DRAIN: begin
                if (v3R && last3R) stateS = DONE;
                else               stateS = DRAIN;
            end
            DONE: begin
                if (outFireS) stateS = IDLE;
                else          stateS = DONE;
            end
            default: stateS = IDLE;
        endcase
    end

    // State and state-decoded handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= IDLE;
            readyR <= 1'b1;
            validR <= 1'b0;
            busyR  <= 1'b0;
        end else begin
            stateR <= stateS;
            readyR <= (stateS == IDLE) || (stateS == ACCUM);
            validR <= (stateS == DONE);
            busyR  <= (stateS != IDLE);
        end
    end

    // Chunk popcounts of the registered closure and their total.
    always_comb begin
        totalS = 8'd0;
        for (int c = 0; c < 8; c++) begin
            chunkS[c] = popcnt16(closureR[c*16 +: 16]);
            totalS    = totalS + {3'd0, chunkR[c]};
        end
    end

    // Three-stage datapath pipeline with a valid/last tag per stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            closureR <= 128'd0;
            for (int c = 0; c < 8; c++) chunkR[c] <= 5'd0;
            totalR   <= 8'd0;
            v1R      <= 1'b0;
            v2R      <= 1'b0;
            v3R      <= 1'b0;
            last1R   <= 1'b0;
            last2R   <= 1'b0;
            last3R   <= 1'b0;
        end else begin
            if (acceptS) closureR <= upClose(bus.in_data);
            else         closureR <= closureR;
            for (int c = 0; c < 8; c++) chunkR[c] <= chunkS[c];
            totalR <= totalS;
            v1R    <= acceptS;
            v2R    <= v1R;
            v3R    <= v2R;
            last1R <= acceptS & bus.in_last;
            last2R <= last1R;
            last3R <= last2R;
        end
    end

    assign sumAddS = {1'b0, sumR} + {{(ACC_WIDTH - 7){1'b0}}, totalR};
    assign cntAddS = {1'b0, countR} + {{COUNT_WIDTH{1'b0}}, 1'b1};

    // Accumulators: cleared by the result handshake, carries feed the sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumR   <= '0;
            countR <= '0;
            ovfR   <= 1'b0;
        end else if (outFireS) begin
            sumR   <= '0;
            countR <= '0;
            ovfR   <= 1'b0;
        end else if (v3R) begin
            sumR   <= sumAddS[ACC_WIDTH-1:0];
            countR <= cntAddS[COUNT_WIDTH-1:0];
            ovfR   <= ovfR | sumAddS[ACC_WIDTH] | cntAddS[COUNT_WIDTH];
        end else begin
            sumR   <= sumR;
            countR <= countR;
            ovfR   <= ovfR;
        end
    end
endmodule

// File: tb/tb_monotonized_popcount_accumulator.sv
// Scoreboard bench: stimulus pushes expected frame results, a negedge monitor pops and compares.
module tb_monotonized_popcount_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    monotonized_popcount_accumulator_if #(.ACC_WIDTH(48), .COUNT_WIDTH(32)) bus ();
    monotonized_popcount_accumulator_if #(.ACC_WIDTH(8),  .COUNT_WIDTH(32)) bus8 ();

    monotonized_popcount_accumulator #(.ACC_WIDTH(48), .COUNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    monotonized_popcount_accumulator #(.ACC_WIDTH(8), .COUNT_WIDTH(32)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [47:0] sum;
        logic [31:0] cnt;
        logic        ovf;
        int unsigned lastEdge;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monE;
    int          checks = 0;
    int          failures = 0;
    int unsigned edges = 0;
    logic        prevValid = 1'b0;
    bit          randReady = 1'b0;
    longint      frSum = 0;
    int          frCnt = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: count entries i for which some submask j of i has d[j] set.
    function automatic int upPop(input logic [127:0] d);
        int n = 0;
        for (int i = 0; i < 128; i++) begin
            bit hit = 0;
            for (int j = 0; j < 128; j++)
                if (((j & ~i) == 0) && d[j]) hit = 1;
            if (hit) n++;
        end
        return n;
    endfunction

    // Offer one vector starting just after a posedge; returns just after its acceptance edge.
    task automatic sendVec(input logic [127:0] d, input logic last, input bit noStall, input bit record);
        int   w;
        exp_t e;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (w >= 60) chk("accept_timeout", 64'(w), 64'd0);
        if (noStall) chk("no_bubble", 64'(w), 64'd0);
        if (record) begin
            frSum += upPop(d);
            frCnt++;
            if (last) begin
                e.sum      = frSum[47:0];
                e.cnt      = frCnt[31:0];
                e.ovf      = (frSum >= 64'h1_0000_0000_0000);
                e.lastEdge = edges + 1;
                sbq.push_back(e);
                frSum = 0;
                frCnt = 0;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_last  = 1'($urandom);
    endtask

    task automatic sendFrame(input logic [127:0] v[$]);
        for (int k = 0; k < v.size(); k++)
            sendVec(v[k], (k == v.size() - 1), (k != 0), 1'b1);
    endtask

    function automatic logic [127:0] randVec();
        logic [127:0] r;
        case ($urandom % 3)
            0: r = 128'd1 << $urandom_range(0, 127);
            1: r = (128'd1 << $urandom_range(0, 127)) | (128'd1 << $urandom_range(64, 127))
                   | (128'd1 << $urandom_range(96, 127));
            default: r = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
                         & {$urandom, $urandom, $urandom, $urandom};
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (randReady) bus.out_ready = ($urandom % 4) != 0;
    end

    // Monitor: latency on out_valid rise, compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !prevValid) begin
                if (sbq.size() > 0) chk("latency", 64'(edges), 64'(sbq[0].lastEdge + 3));
                else chk("spurious_valid", 64'd1, 64'd0);
            end
            if (bus.out_valid && bus.out_ready && sbq.size() > 0) begin
                monE = sbq.pop_front();
                chk("out_sum", 64'(bus.out_sum), 64'(monE.sum));
                chk("out_count", 64'(bus.out_count), 64'(monE.cnt));
                chk("out_overflow", 64'(bus.out_overflow), 64'(monE.ovf));
            end
            prevValid <= bus.out_valid;
        end else begin
            prevValid <= 1'b0;
        end
    end

    initial begin : main
        logic [127:0] fr[$];
        logic [47:0]  snapSum;
        logic [31:0]  snapCnt;
        int           w;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0; bus8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_out_count", 64'(bus.out_count), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Narrow accumulator wraps: 128 + 128 mod 256.
        bus8.in_valid = 1'b1; bus8.in_data = 128'h1; bus8.in_last = 1'b0;
        @(posedge clk); #1;
        bus8.in_last = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        w = 0;
        while (!bus8.out_valid && w < 20) begin @(negedge clk); w++; end
        chk("acc8_wait", 64'(bus8.out_valid), 64'd1);
        chk("acc8_sum", 64'(bus8.out_sum), 64'd0);
        chk("acc8_count", 64'(bus8.out_count), 64'd2);
        chk("acc8_overflow", 64'(bus8.out_overflow), 64'd1);
        @(posedge clk); #1;

        fr = {128'h1};
        sendFrame(fr);
        fr = {128'd1 << 64, 128'h8};
        sendFrame(fr);
        fr = {};
        for (int k = 0; k < 10; k++) fr.push_back(128'd1 << 127);
        sendFrame(fr);
        if (upPop(128'h1) != 128) chk("model_selfcheck", 64'(upPop(128'h1)), 64'd128);

        // Output held off in DONE while input is offered.
        repeat (8) @(posedge clk); #1;
        bus.out_ready = 1'b0;
        sendVec(128'h1, 1'b1, 1'b0, 1'b1);
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 20) begin @(negedge clk); w++; end
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        snapSum = bus.out_sum;
        snapCnt = bus.out_count;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom, $urandom, $urandom}; bus.in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_sum_stable", 64'(bus.out_sum), 64'(snapSum));
            chk("stall_count_stable", 64'(bus.out_count), 64'(snapCnt));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_hs_valid", 64'(bus.out_valid), 64'd0);
        chk("post_hs_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;

        // Reset during DRAIN discards the partial frame.
        sendVec(128'h1, 1'b0, 1'b0, 1'b0);
        sendVec(128'd1 << 127, 1'b1, 1'b0, 1'b0);
        #2;
        chk("drain_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("arst_out_count", 64'(bus.out_count), 64'd0);
        chk("arst_overflow", 64'(bus.out_overflow), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fr = {128'h1};
        sendFrame(fr);

        // Randomized frames with a randomly stalling consumer.
        randReady = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 6);
            fr = {};
            for (int k = 0; k < len; k++) fr.push_back(randVec());
            sendFrame(fr);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        w = 0;
        while (sbq.size() > 0 && w < 300) begin @(posedge clk); w++; end
        chk("drain_scoreboard", 64'(sbq.size()), 64'd0);
        randReady = 1'b0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
